led_display_mode_sequencer: RTL and testbench

Autonomous show controller for the LED panel. It drives `mode_in`/`colour_in` of the pattern generator from a fixed eight-step playlist, holding each step for a programmable dwell time. Mode changes happen only at frame boundaries, with one blank frame between steps. It sits between the board-level controls (enable, advance button, hold switch) and the pattern generator.

---
 rtl/led_display_pkg.sv | 46 ++++
 rtl/led_display_mode_sequencer_if.sv | 25 ++
 rtl/led_seq_dwell_timer.sv | 51 +++++
 rtl/led_display_mode_sequencer.sv | 138 +++++++++++++
 tb/tb_led_display_mode_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/led_display_pkg.sv
// Shared types and constants for the LED show sequencer: mode codes, playlist, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_display_pkg;

    // Pattern generator mode codes
    localparam logic [3:0] MODE_OFF    = 4'd0;
    localparam logic [3:0] MODE_SOLID  = 4'd1;
    localparam logic [3:0] MODE_SCAN_H = 4'd2;
    localparam logic [3:0] MODE_SCAN_V = 4'd3;
    localparam logic [3:0] MODE_PULSE  = 4'd4;

    // Millisecond tick period used when the SIMULATION parameter is set
    localparam int SIM_TICK_PERIOD = 100;

    // One playlist entry; colour is {b,g,r}
    typedef struct packed {
        logic [3:0] mode;
        logic [2:0] colour;
    } seq_step_t;

    localparam seq_step_t PLAYLIST [0:7] = '{
        '{mode: MODE_SOLID,  colour: 3'b001},
        '{mode: MODE_SOLID,  colour: 3'b010},
        '{mode: MODE_SOLID,  colour: 3'b100},
        '{mode: MODE_SCAN_H, colour: 3'b111},
        '{mode: MODE_SCAN_V, colour: 3'b110},
        '{mode: MODE_PULSE,  colour: 3'b101},
        '{mode: MODE_PULSE,  colour: 3'b011},
        '{mode: MODE_OFF,    colour: 3'b000}
    };

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_RUN        = 3'd2,
        ST_WAIT_FRAME = 3'd3,
        ST_BLANK      = 3'd4
    } seq_state_t;

    // Playlist index increment; 3-bit arithmetic gives the 7 -> 0 wrap for free
    function automatic logic [2:0] step_inc(input logic [2:0] s);
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/led_display_mode_sequencer_if.sv
// Board controls in, pattern-generator drive out, for the LED show sequencer.
// Latency: n/a (wires only).
// Backpressure: none; controls are levels/pulses, outputs are always valid.
interface led_display_mode_sequencer_if;
    logic       enable_in;
    logic       advance_in;
    logic       hold_in;
    logic       frame_done_in;
    logic [3:0] mode_out;
    logic [2:0] colour_out;
    logic [2:0] step_out;
    logic       busy_out;

    // Sequencer side
    modport master (
        input  enable_in, advance_in, hold_in, frame_done_in,
        output mode_out, colour_out, step_out, busy_out
    );

    // Board / pattern generator side
    modport slave (
        output enable_in, advance_in, hold_in, frame_done_in,
        input  mode_out, colour_out, step_out, busy_out
    );
endinterface

// File: rtl/led_seq_dwell_timer.sv
// Dwell timer: prescaler makes a ms tick, 16-bit ms counter saturates at DWELL_MS.
// Latency: done_out is a compare on registered state, high from the edge the count reaches DWELL_MS.
// Backpressure: hold_in freezes both prescaler and ms counter; clear_in has priority.
module led_seq_dwell_timer #(
    parameter int TICK_PERIOD = 100,
    parameter int DWELL_MS    = 5000
) (
    input  logic clk_in,
    input  logic n_reset_in,
    input  logic clear_in,
    input  logic hold_in,
    output logic done_out
);
    localparam int                PSC_W    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(TICK_PERIOD - 1);
    localparam logic [15:0]       DWELL    = 16'(DWELL_MS);

    logic [PSC_W-1:0] psc_q, psc_d;
    logic [15:0]      ms_q, ms_d;
    logic             tick;

    // Prescaler wraps at period-1; ms counter advances on the wrap and stops at DWELL
    always_comb begin
        psc_d = psc_q;
        ms_d  = ms_q;
        tick  = (psc_q == PSC_LAST);
        if (clear_in) begin
            psc_d = '0;
            ms_d  = '0;
        end else if (!hold_in) begin
            psc_d = tick ? '0 : psc_q + PSC_W'(1);
            if (tick && (ms_q != DWELL)) begin
                ms_d = ms_q + 16'd1;
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            psc_q <= '0;
            ms_q  <= '0;
        end else begin
            psc_q <= psc_d;
            ms_q  <= ms_d;
        end
    end

    assign done_out = (ms_q == DWELL);

endmodule

// File: rtl/led_display_mode_sequencer.sv
// Show controller: steps the pattern generator through an 8-entry playlist, blank frame between steps.
// Latency: all outputs registered; new step visible 2 cycles after the frame pulse leaving BLANK.
// Backpressure: none; advance_in outside RUN is dropped, hold_in freezes the dwell. Build option LED_SEQ_SHUFFLE_EN.
module led_display_mode_sequencer
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int SIMULATION   = 0,
    parameter int DWELL_MS     = 5000
) (
    input  logic                           clk_in,
    input  logic                           n_reset_in,
    led_display_mode_sequencer_if.master   bus_if
);
    localparam int TICK_PERIOD = (SIMULATION != 0) ? SIM_TICK_PERIOD : (SYS_CLK_FREQ / 1000);

    seq_state_t state_q, state_d;
    logic [2:0] step_q,   step_d;
    logic [3:0] mode_q,   mode_d;
    logic [2:0] colour_q, colour_d;
    logic       busy_q,   busy_d;

    logic       dwell_done;
    logic [2:0] next_step;
    seq_step_t  load_entry;

    assign load_entry = PLAYLIST[step_q];

    led_seq_dwell_timer #(
        .TICK_PERIOD (TICK_PERIOD),
        .DWELL_MS    (DWELL_MS)
    ) u_dwell_timer (
        .clk_in     (clk_in),
        .n_reset_in (n_reset_in),
        .clear_in   (state_q == ST_LOAD),
        .hold_in    (bus_if.hold_in),
        .done_out   (dwell_done)
    );

`ifdef LED_SEQ_SHUFFLE_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4, free-running from reset
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Random pick, bumped by one if it would repeat the current step
    always_comb begin
        next_step = (lfsr_q[2:0] == step_q) ? step_inc(step_q) : lfsr_q[2:0];
    end
`else
    // Sequential playlist order
    always_comb begin
        next_step = step_inc(step_q);
    end
`endif

    // State and output registers
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q  <= ST_IDLE;
            step_q   <= 3'd0;
            mode_q   <= MODE_OFF;
            colour_q <= 3'b000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            mode_q   <= mode_d;
            colour_q <= colour_d;
            busy_q   <= busy_d;
        end
    end

    // Next state; the step only moves on the frame pulse that leaves BLANK
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (!bus_if.enable_in) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       state_d = ST_LOAD;
                ST_LOAD:       state_d = ST_RUN;
                ST_RUN: begin
                    if (dwell_done || bus_if.advance_in) begin
                        state_d = ST_WAIT_FRAME;
                    end
                end
                ST_WAIT_FRAME: begin
                    if (bus_if.frame_done_in) begin
                        state_d = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (bus_if.frame_done_in) begin
                        state_d = ST_LOAD;
                        step_d  = next_step;
                    end
                end
                default:       state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: OFF when idle/disabled or entering BLANK, playlist entry during LOAD, else held
    always_comb begin
        mode_d   = mode_q;
        colour_d = colour_q;
        busy_d   = (state_q == ST_WAIT_FRAME) || (state_q == ST_BLANK);
        if (!bus_if.enable_in || (state_q == ST_IDLE)) begin
            mode_d   = MODE_OFF;
            colour_d = 3'b000;
        end else if (state_q == ST_LOAD) begin
            mode_d   = load_entry.mode;
            colour_d = load_entry.colour;
        end else if ((state_q == ST_WAIT_FRAME) && bus_if.frame_done_in) begin
            mode_d   = MODE_OFF;
            colour_d = 3'b000;
        end
    end

    assign bus_if.mode_out   = mode_q;
    assign bus_if.colour_out = colour_q;
    assign bus_if.step_out   = step_q;
    assign bus_if.busy_out   = busy_q;

endmodule

// File: tb/tb_led_display_mode_sequencer.sv
// Bench for the LED show sequencer: vector table through a scoreboard queue, plus corner sequences.
// Latency: each vector is checked 1ns after the last clock edge it spans.
// Backpressure: n/a.
module tb_led_display_mode_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_display_mode_sequencer_if bus ();

    led_display_mode_sequencer #(
        .SYS_CLK_FREQ (100_000_000),
        .SIMULATION   (1),
        .DWELL_MS     (2)
    ) dut (
        .clk_in     (clk),
        .n_reset_in (rst_n),
        .bus_if     (bus)
    );

    typedef struct packed {
        logic        en;
        logic        adv;
        logic        hold;
        logic        fd;
        logic [15:0] n;
        logic [3:0]  mode;
        logic [2:0]  colour;
        logic [2:0]  step;
        logic        busy;
    } vec_t;

    typedef struct packed {
        logic [3:0] mode;
        logic [2:0] colour;
        logic [2:0] step;
        logic       busy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference playlist {mode, colour}
    function automatic logic [6:0] pl(input int idx);
        case (idx)
            0: return {4'd1, 3'b001};
            1: return {4'd1, 3'b010};
            2: return {4'd1, 3'b100};
            3: return {4'd2, 3'b111};
            4: return {4'd3, 3'b110};
            5: return {4'd4, 3'b101};
            6: return {4'd4, 3'b011};
            default: return {4'd0, 3'b000};
        endcase
    endfunction

    // show < 0 means OFF/000 expected, else the playlist entry at that index
    function automatic vec_t mk(input logic en, input logic adv, input logic hold, input logic fd,
                                input int n, input int show, input int step, input logic busy);
        vec_t v;
        logic [6:0] e;
        v.en   = en;
        v.adv  = adv;
        v.hold = hold;
        v.fd   = fd;
        v.n    = 16'(n);
        e      = (show < 0) ? 7'd0 : pl(show);
        v.mode   = e[6:3];
        v.colour = e[2:0];
        v.step   = 3'(step);
        v.busy   = busy;
        return v;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        n_tests++;
        if ({bus.mode_out, bus.colour_out, bus.step_out, bus.busy_out} !== e) begin
            n_fail++;
            $display("FAIL %s: got mode=%0d colour=%b step=%0d busy=%b, expected mode=%0d colour=%b step=%0d busy=%b",
                     name, bus.mode_out, bus.colour_out, bus.step_out, bus.busy_out,
                     e.mode, e.colour, e.step, e.busy);
        end
    endtask

    // Drive one vector: levels for n cycles, pulses for the first cycle only
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        bus.enable_in     = v.en;
        bus.hold_in       = v.hold;
        bus.advance_in    = v.adv;
        bus.frame_done_in = v.fd;
        exp_q.push_back({v.mode, v.colour, v.step, v.busy});
        for (int i = 0; i < int'(v.n); i++) begin
            @(posedge clk);
            #1;
            bus.advance_in    = 1'b0;
            bus.frame_done_in = 1'b0;
        end
        e = exp_q.pop_front();
        check_out(name, e);
    endtask

`ifdef LED_SEQ_SHUFFLE_EN
    logic [7:0] m_lfsr;
    // Reference LFSR stepping on the same edges as the design
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    initial begin
        bus.enable_in     = 1'b0;
        bus.advance_in    = 1'b0;
        bus.hold_in       = 1'b0;
        bus.frame_done_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_values", '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("after_reset_idle", '0);

`ifndef LED_SEQ_SHUFFLE_EN
        // en adv hold fd  n  show step busy
        vecs.push_back(mk(1, 0, 0, 0,   1, -1, 0, 0));  // IDLE -> LOAD
        vecs.push_back(mk(1, 0, 0, 0,   1,  0, 0, 0));  // LOAD drives step 0
        vecs.push_back(mk(1, 0, 0, 0, 200,  0, 0, 0));  // dwell reached, still RUN
        vecs.push_back(mk(1, 0, 0, 0,   1,  0, 0, 0));  // expiry -> WAIT_FRAME
        vecs.push_back(mk(1, 0, 0, 0,   1,  0, 0, 1));  // busy one cycle later
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 0, 1));  // frame -> BLANK, OFF
        vecs.push_back(mk(1, 0, 0, 0,  10, -1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 1, 1));  // frame -> LOAD, step 1
        vecs.push_back(mk(1, 0, 0, 0,   1,  1, 1, 0));  // SOLID 010 visible
        vecs.push_back(mk(1, 0, 0, 0,  10,  1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 1,   1,  1, 1, 0));  // advance + frame in the exit cycle
        vecs.push_back(mk(1, 0, 0, 0,   3,  1, 1, 1));  // that frame did not count
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0,   1, -1, 1, 1));  // advance in BLANK ignored
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 2, 1));
        vecs.push_back(mk(1, 0, 0, 0,   1,  2, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 200,  2, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0,   1,  2, 2, 0));  // expiry and advance together
        vecs.push_back(mk(1, 0, 0, 0,   1,  2, 2, 1));
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 2, 1));
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 3, 1));  // single increment
        vecs.push_back(mk(1, 0, 0, 0,   1,  3, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0,  50,  3, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 500,  3, 3, 0));  // held: no progress
        vecs.push_back(mk(1, 0, 0, 0, 150,  3, 3, 0));  // 200 unheld cycles done
        vecs.push_back(mk(1, 0, 0, 0,   1,  3, 3, 0));  // -> WAIT_FRAME
        vecs.push_back(mk(1, 0, 0, 0,   1,  3, 3, 1));
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 3, 1));
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 4, 1));
        vecs.push_back(mk(1, 0, 0, 0,   1,  4, 4, 0));
        vecs.push_back(mk(1, 1, 0, 0,   1,  4, 4, 0));  // advance -> WAIT_FRAME
        vecs.push_back(mk(1, 0, 0, 1,   1, -1, 4, 1));  // -> BLANK
        vecs.push_back(mk(0, 0, 0, 0,   1, -1, 4, 1));  // disable in BLANK -> IDLE
        vecs.push_back(mk(0, 0, 0, 1,   3, -1, 4, 0));  // IDLE ignores frames
        vecs.push_back(mk(1, 0, 0, 0,   1, -1, 4, 0));  // re-enable -> LOAD
        vecs.push_back(mk(1, 0, 0, 0,   1,  4, 4, 0));  // same step reloaded

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Advance through 5,6,7 and wrap to 0
        for (int k = 1; k <= 4; k++) begin
            int cur;
            int nxt;
            cur = (3 + k) % 8;
            nxt = (cur + 1) % 8;
            apply(mk(1, 1, 0, 0, 1,  cur, cur, 0), $sformatf("wrap%0d_adv", k));
            apply(mk(1, 0, 0, 1, 1,   -1, cur, 1), $sformatf("wrap%0d_blank", k));
            apply(mk(1, 0, 0, 1, 1,   -1, nxt, 1), $sformatf("wrap%0d_load", k));
            apply(mk(1, 0, 0, 0, 1,  nxt, nxt, 0), $sformatf("wrap%0d_show", k));
        end
`else
        begin
            int cur;
            int nxt;
            logic [7:0] lf;
            apply(mk(1, 0, 0, 0, 1, -1, 0, 0), "shuf_load");
            apply(mk(1, 0, 0, 0, 1,  0, 0, 0), "shuf_first");
            cur = 0;
            for (int t = 0; t < 16; t++) begin
                apply(mk(1, 1, 0, 0, 1, cur, cur, 0), $sformatf("shuf%0d_adv", t));
                apply(mk(1, 0, 0, 1, 1,  -1, cur, 1), $sformatf("shuf%0d_blank", t));
                lf  = m_lfsr;
                nxt = (int'(lf[2:0]) == cur) ? (cur + 1) % 8 : int'(lf[2:0]);
                apply(mk(1, 0, 0, 1, 1,  -1, nxt, 1), $sformatf("shuf%0d_load", t));
                apply(mk(1, 0, 0, 0, 1, nxt, nxt, 0), $sformatf("shuf%0d_show", t));
                n_tests++;
                if (int'(bus.step_out) == cur) begin
                    n_fail++;
                    $display("FAIL shuf%0d_repeat: got step=%0d, required a step other than %0d",
                             t, bus.step_out, cur);
                end
                cur = nxt;
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
